// File: rtl/pixel_frame_sequencer.sv
// Erase/expose/convert sequencer for the pixel array and ramp ADC; phase strobes are registered and appear one cycle after the deciding edge.
// Row words are then streamed one at a time; outValid holds its word until outReady, and no further row is read while it waits.
module pixel_frame_sequencer #(
    parameter int rows           = 2,
    parameter int columns        = 2,
    parameter int ERASE_CYCLES   = 5,
    parameter int CONVERT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [7:0]                            expose_cycles,
    input  logic [8*columns-1:0]                  pixData,
    output logic                                  erase,
    output logic                                  expose,
    output logic                                  convert,
    output logic                                  read,
    output logic [rows-1:0]                       readArray,
    output logic [8*columns-1:0]                  outData,
    output logic [((rows > 1) ? $clog2(rows) : 1)-1:0] outRow,
    output logic                                  outValid,
    input  logic                                  outReady,
    output logic                                  busy,
    output logic                                  frameDone
);

    localparam int RW   = (rows > 1) ? $clog2(rows) : 1;
    localparam int DW   = 8 * columns;
    localparam int MAXP = (ERASE_CYCLES > CONVERT_CYCLES) ? ERASE_CYCLES : CONVERT_CYCLES;
    localparam int CW   = ($clog2(MAXP + 1) > 8) ? $clog2(MAXP + 1) : 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_RDSEL,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      exp_q, exp_d;
    logic [RW-1:0]   row_q, row_d;

    logic            erase_q, erase_d;
    logic            expose_q, expose_d;
    logic            convert_q, convert_d;
    logic            read_q, read_d;
    logic [rows-1:0] ra_q, ra_d;
    logic [DW-1:0]   data_q, data_d;
    logic [RW-1:0]   orow_q, orow_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            last_row;
    logic            handshake;

    assign last_row  = (row_q == RW'(rows - 1));
    assign handshake = (state_q == S_HOLD) && outReady;

    // Phase sequencing: one down-counter, reloaded with the length of each phase as it is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ERASE;
                    cnt_d   = CW'(ERASE_CYCLES - 1);
                    exp_d   = (expose_cycles == 8'd0) ? 8'd1 : expose_cycles;
                    row_d   = '0;
                end
            end
            S_ERASE: begin
                if (cnt_q == '0) begin
                    state_d = S_EXPOSE;
                    cnt_d   = CW'(exp_q) - CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EXPOSE: begin
                if (cnt_q == '0) begin
                    state_d = S_CONVERT;
                    cnt_d   = CW'(CONVERT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CONVERT: begin
                if (cnt_q == '0) begin
                    state_d = S_RDSEL;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RDSEL: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (outReady) begin
                    if (last_row) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        state_d = S_RDSEL;
                        row_d   = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_comb begin
        erase_d   = (state_d == S_ERASE);
        expose_d  = (state_d == S_EXPOSE);
        convert_d = (state_d == S_CONVERT);
        read_d    = (state_d == S_RDSEL);
        valid_d   = (state_d == S_HOLD);
        busy_d    = (state_d != S_IDLE);
        ra_d      = '0;
        for (int i = 0; i < rows; i++) begin
            if (read_d && (row_d == RW'(i))) begin
                ra_d[i] = 1'b1;
            end
        end
        data_d = data_q;
        orow_d = orow_q;
        if (state_q == S_RDSEL) begin
            data_d = pixData;
            orow_d = row_q;
        end else if (state_d == S_IDLE) begin
            data_d = '0;
            orow_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            row_q     <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read_q    <= 1'b0;
            ra_q      <= '0;
            data_q    <= '0;
            orow_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            row_q     <= row_d;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            convert_q <= convert_d;
            read_q    <= read_d;
            ra_q      <= ra_d;
            data_q    <= data_d;
            orow_q    <= orow_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign erase     = erase_q;
    assign expose    = expose_q;
    assign convert   = convert_q;
    assign read      = read_q;
    assign readArray = ra_q;
    assign outData   = data_q;
    assign outRow    = orow_q;
    assign outValid  = valid_q;
    assign busy      = busy_q;
    // Combinational so the pulse lands in the same cycle as the final handshake.
    assign frameDone = handshake && last_row;

endmodule
